// File: rtl/uart_tx_drain.sv
// Drains the DMA UART TX circular buffer onto the serial line as 8N1 frames.
// Owns the buffer pointers and fill level; bytes arrive through a combinational read port.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 234,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              tx_en,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              busy,
  output logic              uart_tx
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE   = 1;
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q;
  logic              pop;
  logic              accept;
  logic              baud_done;

  assign baud_done = (baud_q == BAUD_LAST);
  // A full buffer still takes a push when a pop frees a slot on the same edge.
  assign accept    = push && (!full || pop);
  assign empty     = (level == '0);
  assign full      = (level == LEVEL_FULL);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty && tx_en) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so back-to-back frames have no idle gap.
          if (!empty && tx_en) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    if (state_q == START)     uart_tx = 1'b0;
    else if (state_q == DATA) uart_tx = shift_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_addr <= wr_addr + ADDR_ONE;
      if (pop)    rd_addr <= rd_addr + ADDR_ONE;
      if (push && !accept) overflow <= 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Shift register is pure datapath; its contents only matter after a pop loads it.
  always_ff @(posedge clk) begin
    if (pop)                           shift_q <= rd_data;
    else if (state_q == DATA && baud_done) shift_q <= {1'b0, shift_q[7:1]};
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with CLKS_PER_BIT=4 and a 16x8 buffer model.
module tb_uart_tx_drain;

  localparam int CPB    = 4;
  localparam int ADDR_W = 4;
  localparam int FRAME  = 10 * CPB;

  logic              clk = 1'b0;
  logic              reset;
  logic              push;
  logic              tx_en;
  logic [7:0]        din;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              busy;
  logic              uart_tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .tx_en    (tx_en),
    .rd_data  (rd_data),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  // DMA buffer: written at wr_addr on every push (dropped pushes included), read combinationally.
  always @(posedge clk) if (push) mem[wr_addr] <= din;
  assign rd_data = mem[rd_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // Called at the first cycle of a start bit; returns at the cycle after the stop bit.
  task automatic watch_frame(input logic [7:0] b, input int clr_push_k, input string tag);
    logic [FRAME-1:0] line_obs, line_exp, busy_obs;
    logic [9:0]       fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < FRAME; k++) begin
      line_exp[k] = fr[k / CPB];
      line_obs[k] = uart_tx;
      busy_obs[k] = busy;
      if (k == clr_push_k) push = 1'b0;
      step();
    end
    chk({tag, "_line"}, 64'(line_obs), 64'(line_exp));
    chk({tag, "_busy"}, 64'(busy_obs), {24'd0, {FRAME{1'b1}}});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_tx;
    int bad_busy;
    reset = 1'b1;
    push  = 1'b0;
    tx_en = 1'b0;
    din   = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Scenario 1: reset values, then a quiet line
    step();
    step();
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_uart_tx", 64'(uart_tx), 64'd1);
    reset = 1'b0;
    tx_en = 1'b1;
    step();
    chk("rel_level", 64'(level), 64'd0);
    chk("rel_empty", 64'(empty), 64'd1);
    bad_tx = 0;
    bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      if (uart_tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      step();
    end
    chk("idle50_tx", 64'(bad_tx), 64'd0);
    chk("idle50_busy", 64'(bad_busy), 64'd0);

    // Scenario 2: single byte 0xA5
    din  = 8'hA5;
    push = 1'b1;
    step();
    push = 1'b0;
    chk("s2_level_one", 64'(level), 64'd1);
    chk("s2_empty", 64'(empty), 64'd0);
    chk("s2_tx_idle", 64'(uart_tx), 64'd1);
    chk("s2_busy_pre", 64'(busy), 64'd0);
    step();
    chk("s2_level_zero", 64'(level), 64'd0);
    watch_frame(8'hA5, -1, "s2");
    chk("s2_busy_post", 64'(busy), 64'd0);
    chk("s2_tx_post", 64'(uart_tx), 64'd1);

    // Scenario 3: three consecutive pushes, contiguous frames
    reset_pulse();
    din  = 8'h01;
    push = 1'b1;
    step();
    din = 8'h02;
    step();
    din = 8'h03;
    watch_frame(8'h01, 1, "s3a");
    watch_frame(8'h02, -1, "s3b");
    watch_frame(8'h03, -1, "s3c");
    chk("s3_tx_idle", 64'(uart_tx), 64'd1);
    chk("s3_busy", 64'(busy), 64'd0);
    chk("s3_rd_addr", 64'(rd_addr), 64'd3);
    chk("s3_wr_addr", 64'(wr_addr), 64'd3);
    chk("s3_level", 64'(level), 64'd0);

    // Scenario 4: fill past full with the transmitter held off
    reset_pulse();
    tx_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      din  = 8'(8'h10 + i);
      push = 1'b1;
      step();
      if (i == 15) begin
        chk("s4_full16", 64'(full), 64'd1);
        chk("s4_ovf16", 64'(overflow), 64'd0);
      end
    end
    push = 1'b0;
    chk("s4_level", 64'(level), 64'd16);
    chk("s4_full", 64'(full), 64'd1);
    chk("s4_overflow", 64'(overflow), 64'd1);
    chk("s4_wr_addr", 64'(wr_addr), 64'd0);
    chk("s4_tx_idle", 64'(uart_tx), 64'd1);
    tx_en = 1'b1;
    step();
    chk("s4_level_pop", 64'(level), 64'd15);
    chk("s4_full_pop", 64'(full), 64'd0);
    // Slot 0 was overwritten by the dropped 17th byte
    watch_frame(8'h20, -1, "s4f0");
    for (int i = 1; i < 16; i++) watch_frame(8'(8'h10 + i), -1, "s4f");
    chk("s4_overflow_end", 64'(overflow), 64'd1);
    chk("s4_empty_end", 64'(empty), 64'd1);
    chk("s4_busy_end", 64'(busy), 64'd0);

    // Scenario 5: push on a STOP->START pop edge while full
    reset_pulse();
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din  = 8'(8'h40 + i);
      push = 1'b1;
      step();
    end
    push = 1'b0;
    chk("s5_full", 64'(full), 64'd1);
    tx_en = 1'b1;
    step();
    din  = 8'h60;
    push = 1'b1;
    step();
    push = 1'b0;
    chk("s5_refill_level", 64'(level), 64'd16);
    for (int k = 1; k < FRAME - 1; k++) step();
    chk("s5_stop_tx", 64'(uart_tx), 64'd1);
    chk("s5_pre_full", 64'(full), 64'd1);
    din  = 8'h61;
    push = 1'b1;
    step();
    push = 1'b0;
    chk("s5_level", 64'(level), 64'd16);
    chk("s5_overflow", 64'(overflow), 64'd0);
    chk("s5_wr_addr", 64'(wr_addr), 64'd2);
    chk("s5_rd_addr", 64'(rd_addr), 64'd2);
    chk("s5_start", 64'(uart_tx), 64'd0);
    tx_en = 1'b0;
    reset_pulse();

    // Scenario 6: asynchronous reset mid-frame
    tx_en = 1'b1;
    din   = 8'h3C;
    push  = 1'b1;
    step();
    din = 8'h5A;
    step();
    push = 1'b0;
    for (int k = 0; k < 15; k++) step();
    chk("s6_busy_pre", 64'(busy), 64'd1);
    chk("s6_level_pre", 64'(level), 64'd1);
    reset = 1'b1;
    #1;
    chk("s6_tx", 64'(uart_tx), 64'd1);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_level", 64'(level), 64'd0);
    chk("s6_empty", 64'(empty), 64'd1);
    chk("s6_rd_addr", 64'(rd_addr), 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("s6_tx_rel", 64'(uart_tx), 64'd1);
    din  = 8'hC3;
    push = 1'b1;
    step();
    push = 1'b0;
    step();
    watch_frame(8'hC3, -1, "s6");
    chk("s6_busy_end", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Transmit engine that drains the DMA UART TX circular buffer onto the serial line. It owns the buffer's write and read pointers, tells the DMA which slot to fill on each CPU store, and fetches queued bytes through a combinational read port. Each byte is sent as an 8N1 frame. It sits directly downstream of the DMA TX buffer and drives the `uart_tx` pin.

## Interface
- `CLKS_PER_BIT`, 234: clock cycles per serial bit (27 MHz / 115200); legal range ≥ 2.
- `ADDR_W`, 4: buffer address width; DEPTH = 2**ADDR_W = 16 entries.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  one-cycle pulse. The DMA writes a byte at `wr_addr` on this same edge.
- `tx_en`  in  1  permits new frames to start. A frame already in flight always completes.
- `rd_data`  in  8  buffer contents at `rd_addr`, combinational.
- `wr_addr`  out  ADDR_W  slot the next accepted push writes.
- `rd_addr`  out  ADDR_W  slot of the oldest queued byte.
- `level`  out  ADDR_W+1  number of queued bytes, 0..DEPTH.
- `empty`  out  1  high when `level == 0`.
- `full`  out  1  high when `level == DEPTH`.
- `overflow`  out  1  sticky flag: set when a push is dropped; cleared only by reset.
- `busy`  out  1  high while a frame is on the line.
- `uart_tx`  out  1  serial output; idles high.

## Operation
- All outputs are registered or decoded from registered state.
- Reset values: `wr_addr`=0, `rd_addr`=0, `level`=0, `empty`=1, `full`=0, `overflow`=0, `busy`=0, `uart_tx`=1.
- A push is accepted when `!full || pop`. An accepted push increments `wr_addr` modulo DEPTH.
- A push that is not accepted leaves `wr_addr` unchanged and sets `overflow`. The byte is lost; the DMA's write lands on the oldest unsent slot, and this is accepted behaviour.
- `pop` is a single-cycle internal event that captures `rd_data` into the shift register and increments `rd_addr` modulo DEPTH.
- `level` update per cycle: +1 on accepted push without pop, −1 on pop without push, unchanged when both or neither occur.
- Pointers wrap naturally from 15 to 0. Full and empty are distinguished by `level`, not by pointer equality.
- A push and a pop on the same edge are both honoured, including when `full` is high.
- FSM states:
  - IDLE: `uart_tx`=1, `busy`=0. If `!empty && tx_en`, pop and go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx`=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shifting right after each bit. After bit 7, go to STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles. At its last cycle, if `!empty && tx_en`, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- `busy` is high in START, DATA and STOP.
- Baud counter: counts 0..CLKS_PER_BIT−1 and restarts at 0 on every state or bit change. Its width is `$clog2(CLKS_PER_BIT)`.
- Changing `tx_en` mid-frame has no effect on the current frame.
- Reset mid-frame forces `uart_tx` high immediately (asynchronous), discards all queued bytes and returns the FSM to IDLE.

## Timing
- A push at edge N makes `empty`=0 after N. The DMA's write is also visible on `rd_data` after N.
- From IDLE with `tx_en`=1, the pop happens at edge N+1. `uart_tx` falls after N+1, i.e. 1 cycle of latency from push to start bit.
- A byte is never popped on the same edge it is pushed.
- A frame lasts exactly 10×CLKS_PER_BIT cycles from start-bit fall to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- Sustained rate: one byte per 10×CLKS_PER_BIT cycles.
- `level` and `full` reflect a pop on the same edge that `uart_tx` enters START.

## Test plan
All scenarios use CLKS_PER_BIT=4. The bench models a 16×8 buffer written at `wr_addr` on `push` and read combinationally at `rd_addr`.

1. Reset asserted mid-run, then released → all outputs hold the reset values listed above; `uart_tx`=1 for 50 cycles with nothing queued.
2. Push 0xA5 with `tx_en`=1 → start bit 1 cycle later. Line shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles. `busy` is high for exactly 40 cycles. `level` reads 1 for one cycle, then 0.
3. Push 0x01, 0x02, 0x03 on consecutive cycles → three contiguous frames totalling 120 cycles with no idle gap. Bytes appear in order. `rd_addr` ends at 3.
4. With `tx_en`=0, push 17 bytes → `level`=16, `full`=1, `overflow`=1, `wr_addr`=0, `uart_tx`=1. Raising `tx_en` sends 16 frames; `overflow` stays 1.
5. With the buffer full and a STOP→START pop occurring, push on the pop edge → push accepted, `level` stays 16, `overflow` stays 0, both pointers advance.
6. Assert `reset` at cycle 15 of a frame → `uart_tx`=1 in the same cycle, `busy`=0, `level`=0. A push after release transmits normally.
